// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC target-side claim/complete block.
// Holds gateway state encoding, ID width and the ID range helper.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    IN_SERVICE
  } gateway_state_t;

  localparam int ID_W = 32;
  localparam logic [ID_W-1:0] NONE_ID = '0;

  function automatic logic id_in_range(
    input logic [ID_W-1:0] id,
    input int unsigned     n
  );
    return (id != NONE_ID) && (id <= ID_W'(n));
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: IDLE -> PENDING -> IN_SERVICE -> IDLE.
// Macro PLIC_EDGE_TRIGGER_EN adds edge-mode capture with a one-deep missed flag.
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic irq_src_i,
`ifdef PLIC_EDGE_TRIGGER_EN
  input  logic edge_mode_i,
`endif
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  output logic pending_o,
  output logic in_service_o
);

  gateway_state_t state_q, state_d;
  logic trig;
  logic repend;

`ifdef PLIC_EDGE_TRIGGER_EN
  logic prev_q;
  logic missed_q, missed_d;
  logic rise;

  assign rise   = irq_src_i & ~prev_q;
  assign trig   = edge_mode_i ? rise : irq_src_i;
  assign repend = missed_q | (edge_mode_i & rise);

  // An edge that lands while busy is remembered once; later ones are dropped.
  always_comb begin
    missed_d = missed_q;
    if (complete_hit_i && state_q == IN_SERVICE)
      missed_d = 1'b0;
    else if (edge_mode_i && rise && state_q != IDLE)
      missed_d = 1'b1;
  end

  // Previous irq level and missed flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      prev_q   <= irq_src_i;
      missed_q <= missed_d;
    end
  end
`else
  assign trig   = irq_src_i;
  assign repend = 1'b0;
`endif

  // Gateway next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (trig) state_d = PENDING;
      PENDING:    if (claim_hit_i) state_d = IN_SERVICE;
      IN_SERVICE: if (complete_hit_i)
                    state_d = repend ? PENDING : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Gateway state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign pending_o    = (state_q == PENDING);
  assign in_service_o = (state_q == IN_SERVICE);

endmodule

// File: rtl/plic_claim_complete.sv
// PLIC target front end: gateways, claim/complete handshake, ext_irq.
// Macro PLIC_EDGE_TRIGGER_EN adds the irq_edge_mode port.
module plic_claim_complete #(
  parameter int N_INTERRUPTS = 32,
  parameter int ID_W         = 32
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [N_INTERRUPTS-1:0] irq_src,
  input  logic [N_INTERRUPTS-1:0] irq_enable,
`ifdef PLIC_EDGE_TRIGGER_EN
  input  logic [N_INTERRUPTS-1:0] irq_edge_mode,
`endif
  input  logic [ID_W-1:0]         active_id,
  input  logic [ID_W-1:0]         active_priority,
  input  logic [ID_W-1:0]         threshold,
  input  logic                    claim_req,
  input  logic                    complete_req,
  input  logic [ID_W-1:0]         complete_id,
  output logic [N_INTERRUPTS-1:0] pending_interrupts,
  output logic [N_INTERRUPTS-1:0] in_service,
  output logic                    claim_valid,
  output logic [ID_W-1:0]         claim_id,
  output logic                    ext_irq
);

  import plic_pkg::*;

  logic [N_INTERRUPTS-1:0] pend;
  logic [N_INTERRUPTS-1:0] claim_hit;
  logic [N_INTERRUPTS-1:0] complete_hit;
  logic                    claimable;

  logic            claim_valid_q, claim_valid_d;
  logic [ID_W-1:0] claim_id_q, claim_id_d;
  logic            ext_irq_q, ext_irq_d;

  assign claimable = id_in_range(active_id, N_INTERRUPTS)
                   && (active_priority > threshold);

  for (genvar j = 0; j < N_INTERRUPTS; j++) begin : g_src
    assign claim_hit[j] = claim_req && claimable
                        && (active_id == ID_W'(j + 1));
    assign complete_hit[j] = complete_req
                           && (complete_id == ID_W'(j + 1));

    plic_gateway u_gw (
      .clk            (clk),
      .n_rst          (n_rst),
      .irq_src_i      (irq_src[j]),
`ifdef PLIC_EDGE_TRIGGER_EN
      .edge_mode_i    (irq_edge_mode[j]),
`endif
      .claim_hit_i    (claim_hit[j]),
      .complete_hit_i (complete_hit[j]),
      .pending_o      (pend[j]),
      .in_service_o   (in_service[j])
    );
  end

  // Claim response and registered interrupt request.
  always_comb begin
    claim_valid_d = claim_req;
    claim_id_d    = claim_id_q;
    ext_irq_d     = claimable && !claim_req;
    if (claim_req)
      claim_id_d = claimable ? active_id : NONE_ID;
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      ext_irq_q     <= 1'b0;
    end else begin
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      ext_irq_q     <= ext_irq_d;
    end
  end

  assign pending_interrupts = pend & irq_enable;
  assign claim_valid        = claim_valid_q;
  assign claim_id           = claim_id_q;
  assign ext_irq            = ext_irq_q;

endmodule

// File: tb/tb_plic_claim_complete.sv
// Self-checking bench for plic_claim_complete, N=4, with a resolver model.
// Claim IDs are checked through a scoreboard queue.
module tb_plic_claim_complete;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [N-1:0] irq_src;
  logic [N-1:0] irq_enable;
  logic [N-1:0] irq_edge_mode;
  logic [W-1:0] active_id;
  logic [W-1:0] active_priority;
  logic [W-1:0] threshold;
  logic         claim_req;
  logic         complete_req;
  logic [W-1:0] complete_id;
  logic [N-1:0] pending_interrupts;
  logic [N-1:0] in_service;
  logic         claim_valid;
  logic [W-1:0] claim_id;
  logic         ext_irq;

  logic [W-1:0] prio [N];
  logic [W-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  plic_claim_complete #(
    .N_INTERRUPTS (N),
    .ID_W         (W)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .irq_src            (irq_src),
    .irq_enable         (irq_enable),
`ifdef PLIC_EDGE_TRIGGER_EN
    .irq_edge_mode      (irq_edge_mode),
`endif
    .active_id          (active_id),
    .active_priority    (active_priority),
    .threshold          (threshold),
    .claim_req          (claim_req),
    .complete_req       (complete_req),
    .complete_id        (complete_id),
    .pending_interrupts (pending_interrupts),
    .in_service         (in_service),
    .claim_valid        (claim_valid),
    .claim_id           (claim_id),
    .ext_irq            (ext_irq)
  );

  // Resolver model: highest priority wins, lower ID on ties.
  always_comb begin
    active_id       = '0;
    active_priority = '0;
    for (int j = 0; j < N; j++) begin
      if (pending_interrupts[j] && prio[j] > active_priority) begin
        active_id       = W'(j + 1);
        active_priority = prio[j];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every claim_valid pulse pops one expected ID.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && claim_valid === 1'b1) begin
      if (exp_q.size() == 0)
        chk("claim_unexpected", 32'(claim_valid), 32'd0);
      else
        chk("claim_id", claim_id, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic claim(input logic [W-1:0] exp_id);
    claim_req = 1'b1;
    exp_q.push_back(exp_id);
    tick();
    claim_req = 1'b0;
  endtask

  task automatic complete(input logic [W-1:0] id);
    complete_req = 1'b1;
    complete_id  = id;
    tick();
    complete_req = 1'b0;
    complete_id  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bad_ids [3];
    bad_ids = '{32'd0, 32'd5, 32'd3};
    n_rst         = 1'b0;
    irq_src       = '0;
    irq_enable    = '1;
    irq_edge_mode = '0;
    threshold     = '0;
    claim_req     = 1'b0;
    complete_req  = 1'b0;
    complete_id   = '0;
    for (int j = 0; j < N; j++) prio[j] = '0;

    #12;
    chk("rst_pending", 32'(pending_interrupts), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_claim_valid", 32'(claim_valid), 32'd0);
    chk("rst_claim_id", claim_id, 32'd0);
    chk("rst_ext_irq", 32'(ext_irq), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

`ifdef PLIC_EDGE_TRIGGER_EN
    irq_edge_mode = 4'b0001;
    prio[0]   = 32'd2;
    threshold = 32'd1;
    irq_src = 4'b0001; tick(); irq_src = '0;
    chk("edge_pend", 32'(pending_interrupts), 32'h1);
    claim(32'd1);
    chk("edge_in_svc", 32'(in_service), 32'h1);
    irq_src = 4'b0001; tick(); irq_src = '0; tick();
    irq_src = 4'b0001; tick(); irq_src = '0;
    chk("edge_busy_pend", 32'(pending_interrupts), 32'h0);
    complete(32'd1);
    chk("edge_repend", 32'(pending_interrupts), 32'h1);
    chk("edge_repend_svc", 32'(in_service), 32'h0);
    claim(32'd1);
    complete(32'd1);
    chk("edge_drop_pend", 32'(pending_interrupts), 32'h0);
    chk("edge_drop_svc", 32'(in_service), 32'h0);
    irq_edge_mode = '0;
    prio[0] = '0;
    tick();
`endif

    // Basic level flow
    prio[2]   = 32'd3;
    threshold = 32'd1;
    irq_src   = 4'b0100;
    tick();
    chk("basic_pend_c1", 32'(pending_interrupts), 32'h4);
    chk("basic_ext_c1", 32'(ext_irq), 32'd0);
    tick();
    chk("basic_ext_c2", 32'(ext_irq), 32'd1);
    irq_src = '0;
    claim(32'd3);
    chk("basic_cv", 32'(claim_valid), 32'd1);
    chk("basic_in_svc", 32'(in_service), 32'h4);
    chk("basic_pend", 32'(pending_interrupts), 32'h0);
    chk("basic_ext_drop", 32'(ext_irq), 32'd0);
    tick();
    chk("basic_cv_pulse", 32'(claim_valid), 32'd0);
    chk("basic_id_hold", claim_id, 32'd3);
    complete(32'd3);
    chk("basic_done", 32'(in_service), 32'h0);

    // Threshold: priority equal to threshold is not claimable
    prio[0]   = 32'd2;
    threshold = 32'd2;
    irq_src   = 4'b0001; tick(); irq_src = '0; tick();
    chk("thr_pend", 32'(pending_interrupts), 32'h1);
    chk("thr_ext", 32'(ext_irq), 32'd0);
    claim(32'd0);
    chk("thr_claim_pend", 32'(pending_interrupts), 32'h1);
    chk("thr_claim_svc", 32'(in_service), 32'h0);
    threshold = 32'd1;
    tick();
    chk("thr_ext_lower", 32'(ext_irq), 32'd1);
    claim(32'd1);
    chk("thr_svc", 32'(in_service), 32'h1);

    // Simultaneous complete of ID 1 and claim of ID 4
    prio[3] = 32'd5;
    irq_src = 4'b1000; tick(); irq_src = '0;
    chk("sim_pend", 32'(pending_interrupts), 32'h8);
    claim_req    = 1'b1;
    complete_req = 1'b1;
    complete_id  = 32'd1;
    exp_q.push_back(32'd4);
    tick();
    claim_req    = 1'b0;
    complete_req = 1'b0;
    complete_id  = '0;
    chk("sim_svc", 32'(in_service), 32'h8);
    chk("sim_pend_after", 32'(pending_interrupts), 32'h0);
    complete(32'd4);
    chk("sim_done", 32'(in_service), 32'h0);

    // Level re-pend after complete
    prio[1] = 32'd2;
    irq_src = 4'b0010;
    tick(); tick();
    chk("lvl_ext", 32'(ext_irq), 32'd1);
    claim(32'd2);
    chk("lvl_svc", 32'(in_service), 32'h2);
    tick();
    chk("lvl_ignore", 32'(pending_interrupts), 32'h0);
    complete(32'd2);
    chk("lvl_svc_clr", 32'(in_service), 32'h0);
    chk("lvl_idle", 32'(pending_interrupts), 32'h0);
    tick();
    chk("lvl_repend", 32'(pending_interrupts), 32'h2);
    tick();
    chk("lvl_ext_again", 32'(ext_irq), 32'd1);
    irq_src = '0;
    claim(32'd2);
    complete(32'd2);

    // Bad completes leave state alone
    irq_src = 4'b0001; tick(); irq_src = '0;
    claim(32'd1);
    irq_src = 4'b0100; tick(); irq_src = '0;
    for (int k = 0; k < 3; k++) begin
      complete(bad_ids[k]);
      chk($sformatf("bad_svc_%0d", bad_ids[k]), 32'(in_service), 32'h1);
      chk($sformatf("bad_pend_%0d", bad_ids[k]),
          32'(pending_interrupts), 32'h4);
    end

    // Async reset with two sources in service
    claim(32'd3);
    chk("rst_two_svc", 32'(in_service), 32'h5);
    tick();
    irq_src = 4'b0110;
    n_rst   = 1'b0;
    #1;
    chk("arst_pending", 32'(pending_interrupts), 32'd0);
    chk("arst_in_service", 32'(in_service), 32'd0);
    chk("arst_claim_id", claim_id, 32'd0);
    chk("arst_ext_irq", 32'(ext_irq), 32'd0);
    chk("arst_claim_valid", 32'(claim_valid), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk("arst_repend", 32'(pending_interrupts), 32'h6);
    tick();
    chk("arst_ext", 32'(ext_irq), 32'd1);
    irq_src = '0;
    tick();

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plic_claim_complete.md
Name: plic_claim_complete

Overview:
- Target-side front end of the interrupt controller.
- Per-source gateways latch raw interrupt lines into the pending vector that drives the priority resolver.
- Accepts the resolver's winning ID and priority, raises the CPU external-interrupt line when that priority exceeds the threshold, and runs the claim/complete handshake.
- Tracks in-service sources so a source cannot re-pend until the CPU completes it.

Parameters:
N_INTERRUPTS, 32, number of interrupt sources; source j carries ID j+1, ID 0 means "none".
ID_W, 32, width of ID, priority and threshold fields.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
irq_src  input  N_INTERRUPTS  raw level interrupt lines, already synchronous to clk
irq_enable  input  N_INTERRUPTS  per-source enable from the register block
active_id  input  ID_W  winning ID from the resolver, 0 = none
active_priority  input  ID_W  priority of active_id
threshold  input  ID_W  target priority threshold
claim_req  input  1  single-cycle pulse, CPU read of the claim register
complete_req  input  1  single-cycle pulse, CPU write of the complete register
complete_id  input  ID_W  ID written with complete_req
pending_interrupts  output  N_INTERRUPTS  pending & irq_enable, feeds the resolver
in_service  output  N_INTERRUPTS  claimed but not yet completed
claim_valid  output  1  one-cycle pulse, claim_id valid
claim_id  output  ID_W  claimed ID, 0 if nothing is claimable
ext_irq  output  1  external interrupt request to the CPU

Behaviour:
- Reset (async, n_rst low): all gateways IDLE; pending, in_service, claim_valid, claim_id and ext_irq all 0.
- Gateway FSM per source, states IDLE, PENDING, IN_SERVICE:
  - IDLE -> PENDING when irq_src[j]=1.
  - PENDING -> IN_SERVICE when a claim selects ID j+1.
  - IN_SERVICE -> IDLE on a valid complete for ID j+1.
  - IN_SERVICE ignores irq_src.
- pending bit = (state==PENDING). A disabled source still latches PENDING but is masked from pending_interrupts.
- Once PENDING, a source stays pending if irq_src drops; it is cleared only by a claim.
- Claimable condition: active_id!=0, active_id<=N_INTERRUPTS and active_priority>threshold (strict, unsigned).
- Claim, sampled on the clk edge with claim_req=1:
  - If claimable: claim_id<=active_id, claimed source goes PENDING->IN_SERVICE, claim_valid<=1 for one cycle.
  - Otherwise: claim_id<=0, claim_valid<=1, no state change.
- claim_id holds its value until the next claim.
- Complete: accepted only if 1<=complete_id<=N_INTERRUPTS and that source is IN_SERVICE. Out-of-range, zero or not-in-service IDs are silently ignored.
- Simultaneous claim and complete in one cycle: both are applied.
  - A claim cannot target a source being completed (IN_SERVICE is never pending).
  - A completed source with irq_src still high re-enters PENDING no earlier than the following edge (IDLE sampled next cycle).
- ext_irq is registered: ext_irq <= claimable && !claim_req. It drops the cycle after a claim and re-evaluates from the updated pending vector.
- Latency: irq_src rises in cycle 0 -> pending visible cycle 1 -> ext_irq high cycle 2 (resolver is combinational).
- Back-to-back claim_req pulses are legal. Each uses the active_id present in its own cycle.

Optional Feature:
Macro PLIC_EDGE_TRIGGER_EN.
- Defined: adds input port irq_edge_mode [N_INTERRUPTS].
  - Sources with edge mode set enter PENDING on a 0->1 transition of irq_src, using a registered previous value (reset 0).
  - A rising edge arriving while the source is PENDING or IN_SERVICE sets a one-deep "missed" flag. On complete, the source goes directly to PENDING and the flag clears.
  - Further edges while the flag is set are dropped.
- Undefined: port absent, all sources level-triggered as above.

Decomposition:
- Package plic_pkg holds:
  - gateway_state_t enum {IDLE, PENDING, IN_SERVICE}
  - localparam ID_W=32
  - NONE_ID='0
  - the function id_in_range(id, n)
- One sub-module plic_gateway, one instance per source. Its interface: irq_src bit, claim_hit, complete_hit, pending, in_service (plus edge-mode logic under the macro).
- The top level decodes claim/complete IDs into one-hot hits and handles claim_id/ext_irq.

Test Plan:
- Basic, N=4, priorities driven by the bench model of the resolver:
  - Stimulus: irq_src=4'b0100, priority 3, threshold 1.
  - Required: pending=0100 at cycle 1; ext_irq=1 at cycle 2; claim_req -> claim_id=3, claim_valid pulse, in_service=0100, pending=0000, ext_irq=0.
- Threshold:
  - Stimulus: source 1 pending with priority 2, threshold 2.
  - Required: ext_irq stays 0; claim_req -> claim_id=0, no state change. With threshold 1 the claim returns ID 1.
- Level re-pend:
  - Stimulus: claim ID 2, hold irq_src[1]=1, complete_id=2.
  - Required: in_service clears at the next edge; pending[1]=1 one cycle later; ext_irq reasserts.
- Bad complete:
  - Stimulus: complete_id values 0, 5, and 3 while source 3 is not in service.
  - Required: in_service and pending unchanged.
- Simultaneous events:
  - Stimulus: same cycle, complete ID 1 (in service) plus claim with active_id=4.
  - Required: in_service goes 0001->1000, claim_id=4.
- Reset mid-operation:
  - Stimulus: assert n_rst with two sources in service.
  - Required: all outputs 0 immediately (async); after release, sources with irq_src high pend again at cycle 1.
- Edge mode (PLIC_EDGE_TRIGGER_EN only):
  - Stimulus: two pulses on source 1, the second arriving while it is in service.
  - Required: the second pulse re-pends source 1 immediately on complete; a third pulse during the same service window is dropped.
